// File: rtl/reg_file.sv
// ID-stage general-purpose register file with HI/LO pair.
// Combinational reads, single synchronous write port, entry 0 hard-wired to zero.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic [1:0]            hilo_we,
  input  logic [DATA_WIDTH-1:0] hi_wdata,
  input  logic [DATA_WIDTH-1:0] lo_wdata,
  output logic [DATA_WIDTH-1:0] hi_rdata,
  output logic [DATA_WIDTH-1:0] lo_rdata,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int NUM_PORTS = 3;

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [DATA_WIDTH-1:0] hi_reg;
  logic [DATA_WIDTH-1:0] lo_reg;

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_reg[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      if (hilo_we[1]) hi_reg <= hi_wdata;
      if (hilo_we[0]) lo_reg <= lo_wdata;
    end
  end

  assign hi_rdata = hi_reg;
  assign lo_rdata = lo_reg;

  // Read ports: A, B and debug share identical addressing rules.
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  assign rd_addr[0] = raddr_a;
  assign rd_addr[1] = raddr_b;
  assign rd_addr[2] = dbg_addr;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rd_port
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 : regs_reg[rd_addr[gi]];
    end
  endgenerate

  assign rdata_a  = rd_data[0];
  assign rdata_b  = rd_data[1];
  assign dbg_data = rd_data[2];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  raddr_a = '0, raddr_b = '0, waddr = '0, dbg_addr = '0;
  logic [31:0] rdata_a, rdata_b, dbg_data, hi_rdata, lo_rdata;
  logic [31:0] wdata = '0, hi_wdata = '0, lo_wdata = '0;
  logic        we = 1'b0;
  logic [1:0]  hilo_we = '0;

  always #5 clk = ~clk;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .raddr_a(raddr_a), .rdata_a(rdata_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b),
    .waddr(waddr), .wdata(wdata), .we(we),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    string       tag;
    logic [31:0] a, b, d, hi, lo;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    return m_gpr[addr];
  endfunction

  // One cycle: drive inputs just after the edge, record what the reads must
  // show before the next edge, then advance the model past that edge.
  task automatic cycle(input string tag, input logic r, input logic w_en,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] hw, input logic [31:0] hd,
                       input logic [31:0] ld, input logic [4:0] ra,
                       input logic [4:0] rb, input logic [4:0] rd);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; we = w_en; waddr = wa; wdata = wd;
    hilo_we = hw; hi_wdata = hd; lo_wdata = ld;
    raddr_a = ra; raddr_b = rb; dbg_addr = rd;
    if (r) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end
    e.tag = tag;
    e.a = m_read(ra); e.b = m_read(rb); e.d = m_read(rd);
    e.hi = m_hi; e.lo = m_lo;
    q.push_back(e);
    if (!r) begin
      if (w_en && wa != 5'd0) m_gpr[wa] = wd;
      if (hw[1]) m_hi = hd;
      if (hw[0]) m_lo = ld;
    end
    $display("txn %-8s rst=%0b we=%0b wa=%0d wd=%h hw=%b ra=%0d rb=%0d rd=%0d",
             tag, r, w_en, wa, wd, hw, ra, rb, rd);
  endtask

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s %s got=%h exp=%h", tag, fld, got, exp);
    end
  endtask

  // Monitor: sample between edges, after combinational reads have settled.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, "rdata_a",  rdata_a,  e.a);
      chk(e.tag, "rdata_b",  rdata_b,  e.b);
      chk(e.tag, "dbg_data", dbg_data, e.d);
      chk(e.tag, "hi_rdata", hi_rdata, e.hi);
      chk(e.tag, "lo_rdata", lo_rdata, e.lo);
    end
  end

  initial begin
    logic [4:0]  wa, ra, rb, rd;
    logic [31:0] wd, hd, ld;
    logic [1:0]  hw;
    logic        r, w_en;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;

    cycle("reset",   1, 1, 5'd4, 32'h11111111, 2'b11, 32'h9, 32'h9, 5'd4, 5'd0, 5'd4);
    cycle("reset2",  1, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd4, 5'd5, 5'd6);
    // Write r5, read it, then assert reset between edges.
    cycle("wr_r5",   0, 1, 5'd5, 32'hDEADBEEF, 2'b00, 32'h0, 32'h0, 5'd5, 5'd4, 5'd5);
    cycle("rd_r5",   0, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
    cycle("rst_mid", 1, 1, 5'd5, 32'h12121212, 2'b11, 32'h7, 32'h7, 5'd5, 5'd5, 5'd5);
    cycle("rel_rst", 0, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
    // r0 write is a no-op.
    cycle("wr_r0",   0, 1, 5'd0, 32'h12345678, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    cycle("rd_r0",   0, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    // Same-cycle read of the written entry returns the old value.
    cycle("wr_r7",   0, 1, 5'd7, 32'hA5A5A5A5, 2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    cycle("rd_r7",   0, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    cycle("wr_r31",  0, 1, 5'd31, 32'hFFFFFFFF, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    cycle("rd_r31",  0, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd31, 5'd31, 5'd31);
    // HI/LO together with a GPR write.
    cycle("hilo_r3", 0, 1, 5'd3, 32'h3, 2'b11, 32'h1, 32'h2, 5'd3, 5'd3, 5'd3);
    cycle("rd_r3",   0, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd3, 5'd7, 5'd31);
    cycle("lo_only", 0, 0, 5'd0, 32'h0, 2'b01, 32'hBAD0BAD0, 32'h55, 5'd3, 5'd0, 5'd7);
    cycle("hi_keep", 0, 0, 5'd0, 32'h0, 2'b10, 32'h80000001, 32'hBAD0BAD0, 5'd0, 5'd0, 5'd0);
    cycle("hilo_rst",1, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd3, 5'd7, 5'd31);
    cycle("hilo_rel",0, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd3, 5'd7, 5'd31);

    // Randomized traffic; addresses biased to a small window to force hits.
    for (int n = 0; n < 400; n++) begin
      r    = ($urandom_range(0, 49) == 0);
      w_en = ($urandom_range(0, 3) != 0);
      wa   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rb   = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
      rd   = 5'($urandom_range(0, 31));
      wd   = $urandom;
      hd   = $urandom;
      ld   = $urandom;
      hw   = 2'($urandom_range(0, 3));
      cycle("rand", r, w_en, wa, wd, hw, hd, ld, ra, rb, rd);
    end
    cycle("idle", 0, 0, 5'd0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
